seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Downstream display stage for the sequence-detection lab. Consumes the 4-bit elapsed count from the button-triggered timer, plus other status nibbles, as a 32-bit packed hex word.
- Time-multiplexes eight common-anode 7-segment digits.
- Snapshots its inputs once per full scan round so a value never tears across digits.
- Drives the board digit-enable and segment pins directly. All outputs are active-low.

Parameters:
- SCAN_CNT, 20000, clock cycles each digit is lit (200 us at 100 MHz). Legal range is ≥2. Benches use 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- data  input  32  eight hex nibbles. data[4k+3:4k] is shown on digit k (digit 0 = rightmost). The timer count goes on data[3:0].
- digit_en  input  8  per-digit enable. A 0 blanks that digit.
- dp_en  input  8  per-digit decimal point. A 1 lights the dp.
- refresh  input  1  single-cycle request to reload the shadow registers immediately.
- led_en  output  8  digit anodes, active-low, one-hot-low or all 1.
- seg  output  8  segments {a,b,c,d,e,f,g,dp} on seg[7:0], active-low.

Behaviour:
- Sampling:
  - All state changes on the rising edge of clk.
  - rst is sampled synchronously and overrides everything else.
- Reset values:
  - cnt=0, idx=0.
  - Shadow registers: sh_data=0, sh_en=0, sh_dp=0.
  - Outputs: led_en=8'hFF, seg=8'hFF.
  - Net effect: the display is dark until the first shadow load.
- Scan counter:
  - cnt counts 0..SCAN_CNT-1.
  - At cnt==SCAN_CNT-1, cnt goes to 0 and idx goes to idx+1. idx wraps from 7 to 0 with a 3-bit modular increment.
- Round-end load:
  - Condition: cnt==SCAN_CNT-1 && idx==7.
  - Action: sh_data<=data, sh_en<=digit_en, sh_dp<=dp_en.
  - The new values take effect from digit 0 of the next round.
- refresh:
  - refresh=1 loads all three shadows on that edge.
  - cnt and idx are not disturbed.
  - If refresh coincides with the round-end load, a single load of the current inputs occurs.
- Output register, one-cycle latency from (idx, shadows):
  - led_en <= sh_en[idx] ? ~(8'b1<<idx) : 8'hFF.
  - seg <= sh_en[idx] ? {dec(sh_data nibble idx), ~sh_dp[idx]} : 8'hFF.
- Decoder dec() gives the 7 MSBs {a..g}. With dp off, the full byte is:
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F
  - 8=01, 9=09, A=11, b=C1, C=63, d=85, E=61, F=71
  - dp on clears seg[0].
- Enable invariants:
  - At most one led_en bit is ever 0.
  - led_en is never 0 for a digit whose sh_en bit is 0.
- Inputs held constant still take effect only at a load point. data changing mid-round is invisible until the next load.
- Reset mid-scan: on the next edge, outputs return to 8'hFF/8'hFF and the shadows are cleared. Scanning restarts at digit 0, cnt=0.

Test Plan:
- Reset release:
  - Stimulus: SCAN_CNT=4, digit_en=FF, data=0, hold rst 3 cycles then release.
  - Response: led_en=FF and seg=FF until the first load at end of round 1 (cycle 32 after release).
  - Then: led_en=FE, seg=03 for 4 cycles, followed by FD/03 and so on.
- Timer count display:
  - Stimulus: data=32'h0000_0008, digit_en=01, pulse refresh.
  - Response: from the cycle after the refresh edge, scanning continues from the current idx, and led_en=FE only while idx==0.
  - On that digit seg=01. All other digit slots show led_en=FF, seg=FF.
- Full decoder sweep:
  - Stimulus: data=32'h7654_3210, then 32'hFEDC_BA98, with dp_en=00 and refresh before each.
  - Response: each digit's seg matches the 16-entry table.
- Decimal point:
  - Stimulus: dp_en=8'h04, data=0, digit_en=FF.
  - Response: digit 2 shows seg=02. All other digits show seg=03.
- Tear-free update:
  - Stimulus: change data from 0 to 32'h1111_1111 while idx==3, without refresh.
  - Response: digits 3–7 still show 03 for the rest of the round. All digits show 9F from the next round.
- Reset mid-scan:
  - Stimulus: assert rst while idx==5, cnt==2.
  - Response: the next cycle has led_en=FF and seg=FF. After release, with digit_en=FF loaded by refresh, the first lit digit is digit 0 (led_en=FE).

Source files
------------

// File: rtl/seg_scan_display.sv
// Eight-digit common-anode 7-segment scanner.
// Inputs are captured into shadow registers once per full scan round, or on
// demand via refresh, so a displayed value never tears across digits.
// Digit anodes and segments are registered and active-low.
module seg_scan_display #(
    parameter int SCAN_CNT = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  digit_en,
    input  logic [7:0]  dp_en,
    input  logic        refresh,
    output logic [7:0]  led_en,
    output logic [7:0]  seg
);

    localparam int                 CNT_W    = $clog2(SCAN_CNT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCAN_CNT - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      sh_data;
    logic [7:0]       sh_en;
    logic [7:0]       sh_dp;

    logic             digit_end;
    logic             load;
    logic [3:0]       nibble;
    logic [7:0]       glyph;
    logic [7:0]       led_next;
    logic [7:0]       seg_next;

    assign digit_end = (cnt == CNT_LAST);
    assign load      = refresh || (digit_end && (idx == 3'd7));

    // Dwell counter and digit index; idx wraps 7 -> 0 naturally in 3 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (digit_end) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow capture at round end or on refresh (a coincident pair is one load).
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_data <= '0;
            sh_en   <= '0;
            sh_dp   <= '0;
        end else if (load) begin
            sh_data <= data;
            sh_en   <= digit_en;
            sh_dp   <= dp_en;
        end
    end

    // Hex-to-segment decode of the current digit; glyph is the full byte with dp off.
    always_comb begin
        nibble = sh_data[{idx, 2'b00} +: 4];
        glyph  = 8'hFF;
        case (nibble)
            4'h0: glyph = 8'h03;
            4'h1: glyph = 8'h9F;
            4'h2: glyph = 8'h25;
            4'h3: glyph = 8'h0D;
            4'h4: glyph = 8'h99;
            4'h5: glyph = 8'h49;
            4'h6: glyph = 8'h41;
            4'h7: glyph = 8'h1F;
            4'h8: glyph = 8'h01;
            4'h9: glyph = 8'h09;
            4'hA: glyph = 8'h11;
            4'hB: glyph = 8'hC1;
            4'hC: glyph = 8'h63;
            4'hD: glyph = 8'h85;
            4'hE: glyph = 8'h61;
            4'hF: glyph = 8'h71;
            default: glyph = 8'hFF;
        endcase
        if (sh_en[idx]) begin
            led_next = ~(8'h01 << idx);
            seg_next = {glyph[7:1], ~sh_dp[idx]};
        end else begin
            led_next = 8'hFF;
            seg_next = 8'hFF;
        end
    end

    // Registered pin drivers; dark after reset until the first shadow load.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_en <= 8'hFF;
            seg    <= 8'hFF;
        end else begin
            led_en <= led_next;
            seg    <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display with a time-based reference model.
module tb_seg_scan_display;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  digit_en;
    logic [7:0]  dp_en;
    logic        refresh;
    logic [7:0]  led_en;
    logic [7:0]  seg;

    seg_scan_display #(.SCAN_CNT(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .digit_en (digit_en),
        .dp_en    (dp_en),
        .refresh  (refresh),
        .led_en   (led_en),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference model: elapsed edges since reset determine the scanned digit.
    int unsigned mk;
    logic [31:0] m_data;
    logic [7:0]  m_en;
    logic [7:0]  m_dp;
    logic [7:0]  gl [16];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        int unsigned digit;
        logic [7:0]  exp_seg;
    } vec_t;
    vec_t vecs [20];

    function automatic int unsigned m_idx();
        return (mk / S) % 8;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock: predict outputs from the pre-edge model, advance model, compare.
    task automatic tick();
        logic [7:0] el, es;
        int unsigned mi;
        el = 8'hFF;
        es = 8'hFF;
        mi = m_idx();
        if (!rst && m_en[mi]) begin
            el = ~(8'h01 << mi);
            es = {gl[m_data[mi*4 +: 4]][7:1], ~m_dp[mi]};
        end
        if (rst) begin
            mk = 0;
            m_data = '0;
            m_en = '0;
            m_dp = '0;
        end else begin
            if (refresh || ((mk % S) == S - 1 && mi == 7)) begin
                m_data = data;
                m_en = digit_en;
                m_dp = dp_en;
            end
            mk++;
        end
        @(posedge clk);
        #1;
        chk("led_en", led_en, el);
        chk("seg", seg, es);
        chk("one_anode", ($countones(~led_en) <= 1), 1);
    endtask

    task automatic wait_digit(input int unsigned d);
        logic [7:0] want;
        bit found;
        want = ~(8'h01 << d);
        found = 0;
        for (int i = 0; i < 8 * S + 2 && !found; i++) begin
            tick();
            if (led_en == want) found = 1;
        end
        chk("wait_digit", found, 1);
    endtask

    initial begin
        logic [7:0] lo_tab [8];
        logic [7:0] hi_tab [8];
        int unsigned lit;
        bit found;

        gl = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        lo_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
        hi_tab = '{8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        for (int i = 0; i < 8; i++) begin
            vecs[i]     = '{32'h7654_3210, 8'h00, i, lo_tab[i]};
            vecs[8 + i] = '{32'hFEDC_BA98, 8'h00, i, hi_tab[i]};
        end
        vecs[16] = '{32'h0000_0000, 8'h04, 2, 8'h02};
        vecs[17] = '{32'h0000_0000, 8'h04, 3, 8'h03};
        vecs[18] = '{32'h7654_3210, 8'hFF, 5, 8'h48};
        vecs[19] = '{32'hFEDC_BA98, 8'h80, 7, 8'h70};

        mk = 0;
        m_data = '0;
        m_en = '0;
        m_dp = '0;

        // Reset release: dark for a full round, then digit 0 shows '0'.
        rst = 1; data = '0; digit_en = 8'hFF; dp_en = '0; refresh = 0;
        repeat (3) tick();
        rst = 0;
        repeat (32) tick();
        chk("dark_before_load", {led_en, seg}, 16'hFFFF);
        tick();
        chk("first_led", led_en, 8'hFE);
        chk("first_seg", seg, 8'h03);
        repeat (3) tick();
        chk("digit0_hold", led_en, 8'hFE);
        tick();
        chk("digit1_led", led_en, 8'hFD);
        chk("digit1_seg", seg, 8'h03);

        // Timer count on digit 0 only.
        data = 32'h0000_0008; digit_en = 8'h01; refresh = 1;
        tick();
        refresh = 0;
        lit = 0;
        repeat (8 * S) begin
            tick();
            if (led_en == 8'hFE) begin
                lit++;
                chk("timer_seg", seg, 8'h01);
            end else begin
                chk("blank_led", led_en, 8'hFF);
                chk("blank_seg", seg, 8'hFF);
            end
        end
        chk("timer_lit_cycles", lit, S);

        // Decoder sweep and decimal points, table-driven.
        foreach (vecs[v]) begin
            data = vecs[v].data; dp_en = vecs[v].dp; digit_en = 8'hFF; refresh = 1;
            tick();
            refresh = 0;
            wait_digit(vecs[v].digit);
            chk($sformatf("vec%0d_seg", v), seg, vecs[v].exp_seg);
        end

        // Tear-free update: change data at digit 3 with no refresh.
        data = '0; dp_en = '0; digit_en = 8'hFF; refresh = 1;
        tick();
        refresh = 0;
        found = 0;
        for (int i = 0; i < 8 * S + 1 && !found; i++) begin
            if (m_idx() == 3) found = 1;
            else tick();
        end
        chk("reach_idx3", found, 1);
        data = 32'h1111_1111;
        for (int i = 0; i < 6 * S && m_idx() != 0; i++) begin
            tick();
            if (led_en != 8'hFF) chk("tear_old", seg, 8'h03);
        end
        chk("tear_round_end", m_idx(), 0);
        repeat (8 * S) begin
            tick();
            if (led_en != 8'hFF) chk("tear_new", seg, 8'h9F);
        end

        // Randomized traffic against the model.
        repeat (800) begin
            data = $urandom;
            digit_en = 8'($urandom);
            dp_en = 8'($urandom);
            refresh = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0; refresh = 0;

        // Reset mid-scan at idx 5, cnt 2.
        digit_en = 8'hFF; data = '0; dp_en = '0; refresh = 1;
        tick();
        refresh = 0;
        found = 0;
        for (int i = 0; i < 8 * S + 1 && !found; i++) begin
            if ((mk % S) == 2 && m_idx() == 5) found = 1;
            else tick();
        end
        chk("reach_idx5_cnt2", found, 1);
        rst = 1;
        tick();
        chk("rst_led", led_en, 8'hFF);
        chk("rst_seg", seg, 8'hFF);
        rst = 0; refresh = 1;
        tick();
        refresh = 0;
        tick();
        chk("restart_led", led_en, 8'hFE);
        chk("restart_seg", seg, 8'h03);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
